// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered N-to-1 valid/ready stream multiplexer.
// The channel is chosen by an external select (force_en/force_sel) or by
// internal arbitration (MODE 0 = fixed priority, MODE 1 = round-robin).
// The chosen word goes into a one-entry output register. That register can
// drain and refill in the same cycle, so a continuous stream has no bubbles.
module stream_mux_arb #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic                 force_en,
  input  logic [SEL_W-1:0]     force_sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  // The valid vector is padded to the full select range. A forced index at or
  // beyond N then reads a zero bit and produces no grant, with no separate
  // range compare.
  localparam int PAD = 2 ** SEL_W;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_reg;
  logic              out_valid_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic [SEL_W-1:0]  out_sel_reg;
  logic [SEL_W-1:0]  ptr_reg;

  logic              can_accept;
  logic [N-1:0]      grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  logic [PAD-1:0]    valid_pad;
  logic [WIDTH-1:0]  ch_data [N];

  // Split the flat input bus into one word per channel.
  for (genvar gi = 0; gi < N; gi++) begin : g_split
    assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  assign valid_pad  = PAD'(in_valid);
  assign can_accept = (state_reg == EMPTY) | out_ready;

  // Grant selection. Each loop runs from the highest candidate down to the
  // lowest, so the last match, which is the highest-priority one, wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (rst_n && can_accept) begin
      if (force_en) begin
        if (valid_pad[force_sel]) begin
          grant_any = 1'b1;
          grant_idx = force_sel;
        end
      end else if (MODE == 0) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          if (in_valid[(int'(ptr_reg) + k) % N]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'((int'(ptr_reg) + k) % N);
          end
        end
      end
      if (grant_any) begin
        grant[grant_idx] = 1'b1;
      end
    end
  end

  assign in_ready = grant;

  // Output register FSM, data capture and round-robin pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else begin
      if (grant_any) begin
        state_reg     <= FULL;
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant_idx];
        out_sel_reg   <= grant_idx;
        // Only arbitrated grants move the pointer. A forced grant is an
        // override and must not disturb the fairness order.
        if (MODE == 1 && !force_en) begin
          ptr_reg <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
      end else if (state_reg == FULL && out_ready) begin
        state_reg     <= EMPTY;
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Testbench for stream_mux_arb.
// Instance A: N=4, round-robin. Instance B: N=5, fixed priority, which makes
// out-of-range force selects reachable. Both instances are checked every
// cycle against a transaction-level reference model.
module tb_stream_mux_arb;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]     a_valid;
  logic [4*W-1:0] a_data;
  logic [3:0]     a_ready;
  logic           a_fen;
  logic [1:0]     a_fsel;
  logic           a_ov;
  logic [W-1:0]   a_od;
  logic [1:0]     a_os;
  logic           a_or;

  logic [4:0]     b_valid;
  logic [5*W-1:0] b_data;
  logic [4:0]     b_ready;
  logic           b_fen;
  logic [2:0]     b_fsel;
  logic           b_ov;
  logic [W-1:0]   b_od;
  logic [2:0]     b_os;
  logic           b_or;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          v;
    logic [63:0] d;
    int          sel;
    int          ptr;
  } ref_t;

  ref_t ra, rb;

  stream_mux_arb #(.WIDTH(W), .N(4), .MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .force_en(a_fen), .force_sel(a_fsel),
    .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_or)
  );

  stream_mux_arb #(.WIDTH(W), .N(5), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .force_en(b_fen), .force_sel(b_fsel),
    .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(b_or)
  );

  always #5 clk = ~clk;

  // Which channel is served this cycle, or -1 for none.
  function automatic int pick(input logic [15:0] valid, input int n, input int mode,
                              input int ptr, input bit fen, input int fsel, input bit can);
    if (!can) return -1;
    if (fen) return (fsel < n && valid[fsel]) ? fsel : -1;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (mode == 1) ? (ptr + k) % n : k;
      if (valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int g);
    return (g < 0) ? 64'd0 : (64'd1 << g);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Compare at the falling edge, then advance the model
  // at the rising edge, then return 1 time unit after that edge.
  task automatic step();
    int ga, gb;
    @(negedge clk);
    ga = -1;
    gb = -1;
    if (rst_n) begin
      ga = pick({12'b0, a_valid}, 4, 1, ra.ptr, a_fen, int'(a_fsel), !ra.v || a_or);
      gb = pick({11'b0, b_valid}, 5, 0, rb.ptr, b_fen, int'(b_fsel), !rb.v || b_or);
    end
    check("a_in_ready",  64'(a_ready), onehot(ga));
    check("a_out_valid", 64'(a_ov),    64'(ra.v));
    check("a_out_data",  a_od,         ra.d);
    check("a_out_sel",   64'(a_os),    64'(ra.sel));
    check("b_in_ready",  64'(b_ready), onehot(gb));
    check("b_out_valid", 64'(b_ov),    64'(rb.v));
    check("b_out_data",  b_od,         rb.d);
    check("b_out_sel",   64'(b_os),    64'(rb.sel));
    @(posedge clk);
    if (rst_n) begin
      if (ga >= 0) begin
        ra.v = 1'b1;
        ra.d = a_data[ga*W +: W];
        ra.sel = ga;
        if (!a_fen) ra.ptr = (ga + 1) % 4;
        $display("xfer A ch=%0d data=%h", ga, ra.d);
      end else if (ra.v && a_or) begin
        ra.v = 1'b0;
      end
      if (gb >= 0) begin
        rb.v = 1'b1;
        rb.d = b_data[gb*W +: W];
        rb.sel = gb;
        $display("xfer B ch=%0d data=%h", gb, rb.d);
      end else if (rb.v && b_or) begin
        rb.v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    ra = '{v: 1'b0, d: 64'd0, sel: 0, ptr: 0};
    rb = '{v: 1'b0, d: 64'd0, sel: 0, ptr: 0};
  endtask

  initial begin
    model_reset();
    a_valid = 4'hF; a_data = '0; a_fen = 1'b0; a_fsel = '0; a_or = 1'b1;
    b_valid = 5'h1F; b_data = '0; b_fen = 1'b0; b_fsel = '0; b_or = 1'b1;
    rst_n = 1'b0;

    // Reset held with every input valid: nothing granted, outputs cleared.
    step();
    step();
    rst_n = 1'b1;

    // Round-robin with all channels valid: serves 0,1,2,3,0,... back to back.
    for (int i = 0; i < 4; i++) a_data[i*W +: W] = 64'hA0 + 64'(i);
    b_valid = '0;
    for (int s = 0; s < 9; s++) step();

    // Fixed priority on B: channel 1 wins until it drops, then channel 2.
    for (int i = 0; i < 5; i++) b_data[i*W +: W] = 64'hB0 + 64'(i);
    b_valid = 5'b00110;
    for (int s = 0; s < 4; s++) step();
    b_valid = 5'b00100;
    step();
    step();
    b_valid = '0;
    step();

    // Backpressure: 0xDEAD held for 5 cycles, then drained and refilled in one cycle.
    a_valid = 4'b0001;
    a_data[0 +: W] = 64'hDEAD;
    step();
    a_or = 1'b0;
    a_valid = 4'hF;
    a_data[0 +: W] = 64'h1111;
    for (int s = 0; s < 5; s++) step();
    a_or = 1'b1;
    step();
    step();

    // Forced select: only channel 2 served; the pointer keeps its position.
    a_fen = 1'b1;
    a_fsel = 2'd2;
    for (int s = 0; s < 3; s++) step();
    a_fen = 1'b0;
    for (int s = 0; s < 3; s++) step();

    // Out-of-range force on the 5-channel instance: no grant, output drains.
    b_valid = 5'h1F;
    b_fen = 1'b1;
    for (int f = 5; f < 8; f++) begin
      b_fsel = 3'(f);
      step();
    end
    b_fsel = 3'd4;
    step();
    b_fen = 1'b0;
    step();

    // Async reset mid-stream, asserted between clock edges.
    a_valid = 4'hF;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_a_out_valid", 64'(a_ov), 64'd0);
    check("async_a_in_ready",  64'(a_ready), 64'd0);
    check("async_b_out_valid", 64'(b_ov), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_a_sel", 64'(a_os), 64'd0);
    step();

    // Randomized traffic on both instances.
    for (int s = 0; s < 400; s++) begin
      a_valid = 4'($urandom);
      b_valid = 5'($urandom);
      for (int i = 0; i < 4; i++) a_data[i*W +: W] = {$urandom, $urandom};
      for (int i = 0; i < 5; i++) b_data[i*W +: W] = {$urandom, $urandom};
      a_fen = ($urandom_range(0, 4) == 0);
      b_fen = ($urandom_range(0, 4) == 0);
      a_fsel = 2'($urandom);
      b_fsel = 3'($urandom);
      a_or = ($urandom_range(0, 3) != 0);
      b_or = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
